// File: rtl/fetch_ctrl.sv
// fetch_ctrl: in-order instruction fetch sequencer with a PC-tagged response FIFO.
// Redirects flush the FIFO and drop responses still in flight for the old path.
module fetch_ctrl #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        dec_ready,
    output logic        dbg_flush
);
    // Handshakes: a request transfers on a rising edge with imem_req_valid && imem_req_ready;
    // a response is a one-cycle imem_rsp_valid pulse that cannot be stalled; decode takes the
    // head on a rising edge with if_valid && dec_ready.

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {FETCH = 1'b0, FLUSH = 1'b1} state_t;

    state_t        state, state_next;
    logic [31:0]   pc, rsp_pc, redirect_tgt;
    logic [CW-1:0] fifo_cnt, out_cnt, drop_cnt, drop_next;
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [31:0]   fifo_instr [DEPTH];
    logic [31:0]   fifo_pc    [DEPTH];
    logic          pop, push, accept, rsp_fire, credit_ok;
    logic [CW:0]   credit_sum;

    assign redirect_tgt = {redirect_pc[31:2], 2'b00};

    assign if_valid = (fifo_cnt != '0);
    assign if_instr = if_valid ? fifo_instr[rd_ptr] : '0;
    assign if_pc    = if_valid ? fifo_pc[rd_ptr] : '0;

    assign pop      = if_valid & dec_ready;
    assign rsp_fire = imem_rsp_valid & (out_cnt != '0);
    assign push     = rsp_fire & ~redirect_valid & (drop_cnt == '0);

    // A slot freed by this cycle's pop can be re-requested immediately.
    assign credit_sum = {1'b0, fifo_cnt} - {{CW{1'b0}}, pop} + {1'b0, out_cnt};
    assign credit_ok  = (credit_sum < (CW+1)'(DEPTH));

    assign imem_req_valid = rst_n & (state == FETCH) & credit_ok & ~redirect_valid;
    assign imem_req_addr  = rst_n ? pc : '0;
    assign accept         = imem_req_valid & imem_req_ready;
    assign dbg_flush      = (state == FLUSH);

    // Everything still in flight at a redirect is stale; earlier drops are already in out_cnt.
    always_comb begin
        drop_next  = drop_cnt;
        state_next = state;
        if (redirect_valid)
            drop_next = out_cnt - CW'(rsp_fire);
        else if (rsp_fire && (drop_cnt != '0))
            drop_next = drop_cnt - CW'(1);
        case (state)
            FETCH:   if (drop_next != '0) state_next = FLUSH;
            FLUSH:   if (drop_next == '0) state_next = FETCH;
            default: state_next = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FETCH;
            pc       <= RESET_PC;
            rsp_pc   <= RESET_PC;
            fifo_cnt <= '0;
            out_cnt  <= '0;
            drop_cnt <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            state    <= state_next;
            drop_cnt <= drop_next;
            out_cnt  <= out_cnt + CW'(accept) - CW'(rsp_fire);
            if (redirect_valid) begin
                pc       <= redirect_tgt;
                rsp_pc   <= redirect_tgt;
                fifo_cnt <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
            end else begin
                if (accept)
                    pc <= pc + 32'd4;
                if (push) begin
                    rsp_pc <= rsp_pc + 32'd4;
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop)
                    rd_ptr <= rd_ptr + AW'(1);
                fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_instr[wr_ptr] <= imem_rsp_data;
            fifo_pc[wr_ptr]    <= rsp_pc;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: in-order memory model with programmable latency, delivery scoreboard,
// redirect alignment table and hand-written redirect/flush/reset sequences.
module tb_fetch_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        dec_ready;
    logic        dbg_flush;

    always #5 clk = ~clk;

    fetch_ctrl #(.DEPTH(2), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .dec_ready(dec_ready), .dbg_flush(dbg_flush)
    );

    int vectors = 0;
    int miscompares = 0;
    int lat = 1;
    int cyc = 0;
    logic [31:0] exp_q[$];

    typedef struct { logic [31:0] addr; int due; } pend_t;
    pend_t pend_q[$];

    typedef struct { logic [31:0] rpc; logic [31:0] a0; logic [31:0] a1; } vec_t;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load_exp(input logic [31:0] start, input int n);
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
    endtask

    task automatic wait_if_valid(input string name, input int limit);
        int n = 0;
        @(negedge clk);
        while (!if_valid && n < limit) begin
            @(negedge clk);
            n++;
        end
        check({name, "_if_valid_seen"}, 32'(if_valid), 32'd1);
    endtask

    // Memory model: accepts sampled mid-cycle, responses returned in order after lat cycles.
    always @(negedge clk) begin
        if (!rst_n)
            pend_q.delete();
        else if (imem_req_valid && imem_req_ready)
            pend_q.push_back('{addr: imem_req_addr, due: cyc + lat});
    end

    always @(posedge clk) begin
        cyc++;
        #1;
        if (!rst_n) begin
            pend_q.delete();
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end else if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend_q[0].addr);
            void'(pend_q.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    end

    // Scoreboard: every word taken by decode must be the next expected PC and its word.
    always @(negedge clk) begin : monitor
        logic [31:0] e;
        if (rst_n && if_valid && dec_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL deliver_unexpected: got pc %h, expected no delivery", if_pc);
            end else begin
                e = exp_q.pop_front();
                check("deliver_pc", if_pc, e);
                check("deliver_instr", if_instr, mem_word(e));
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1);
    end

    initial begin
        vec_t tbl[5];
        logic exp_v[5];
        tbl[0] = '{rpc: 32'h0000_0103, a0: 32'h0000_0100, a1: 32'h0000_0104};
        tbl[1] = '{rpc: 32'hFFFF_FFFC, a0: 32'hFFFF_FFFC, a1: 32'h0000_0000};
        tbl[2] = '{rpc: 32'h0000_0002, a0: 32'h0000_0000, a1: 32'h0000_0004};
        tbl[3] = '{rpc: 32'h0000_07FF, a0: 32'h0000_07FC, a1: 32'h0000_0800};
        tbl[4] = '{rpc: 32'h1234_5678, a0: 32'h1234_5678, a1: 32'h1234_567C};
        exp_v = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

        rst_n = 1'b0; imem_req_ready = 1'b1; dec_ready = 1'b1;
        redirect_valid = 1'b0; redirect_pc = '0;
        step(2);

        // Reset: all outputs zero even with ready/dec_ready high
        @(negedge clk);
        check("reset_req_valid", 32'(imem_req_valid), 32'd0);
        check("reset_req_addr", imem_req_addr, 32'd0);
        check("reset_if_valid", 32'(if_valid), 32'd0);
        check("reset_if_instr", if_instr, 32'd0);
        check("reset_if_pc", if_pc, 32'd0);
        check("reset_flush", 32'(dbg_flush), 32'd0);

        // 1: streaming fetch, 1-cycle latency
        lat = 1;
        load_exp(32'h0, 64);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("t1_req_valid", 32'(imem_req_valid), 32'd1);
            check("t1_req_addr", imem_req_addr, 32'(4 * i));
            check("t1_if_valid", 32'(if_valid), (i >= 2) ? 32'd1 : 32'd0);
            step();
        end

        // 2: decode stalled from reset, two words buffered, then drained
        rst_n = 1'b0;
        step(2);
        dec_ready = 1'b0;
        load_exp(32'h0, 64);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t2_req_valid", 32'(imem_req_valid), 32'(exp_v[i]));
            step();
        end
        @(negedge clk);
        check("t2_if_valid", 32'(if_valid), 32'd1);
        check("t2_if_pc", if_pc, 32'h0);
        step();
        dec_ready = 1'b1;
        @(negedge clk);
        check("t2_resume_valid", 32'(imem_req_valid), 32'd1);
        check("t2_resume_addr", imem_req_addr, 32'h8);
        step(8);

        // 3: redirect with two requests in flight (3-cycle latency)
        rst_n = 1'b0;
        lat = 3;
        step(2);
        load_exp(32'h0, 64);
        rst_n = 1'b1;
        step(2);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0100;
        @(negedge clk);
        check("t3_req_valid_at_redirect", 32'(imem_req_valid), 32'd0);
        step();
        redirect_valid = 1'b0;
        load_exp(32'h100, 64);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t3_flush", 32'(dbg_flush), (i < 2) ? 32'd1 : 32'd0);
            check("t3_req_valid", 32'(imem_req_valid), (i < 2) ? 32'd0 : 32'd1);
            check("t3_if_valid", 32'(if_valid), 32'd0);
            if (i == 2) check("t3_req_addr", imem_req_addr, 32'h100);
            step();
        end
        wait_if_valid("t3", 20);
        check("t3_first_if_pc", if_pc, 32'h100);
        step(10);

        // 4: memory not ready, request held, redirect mid-wait
        rst_n = 1'b0;
        lat = 1;
        imem_req_ready = 1'b0;
        step(2);
        load_exp(32'h0, 64);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_hold_valid", 32'(imem_req_valid), 32'd1);
            check("t4_hold_addr", imem_req_addr, 32'h0);
            step();
        end
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0040;
        @(negedge clk);
        check("t4_redirect_valid", 32'(imem_req_valid), 32'd0);
        step();
        redirect_valid = 1'b0;
        load_exp(32'h40, 64);
        @(negedge clk);
        check("t4_new_valid", 32'(imem_req_valid), 32'd1);
        check("t4_new_addr", imem_req_addr, 32'h40);
        step();
        imem_req_ready = 1'b1;
        step(8);

        // 5: redirect target alignment and PC wrap
        for (int k = 0; k < 5; k++) begin
            imem_req_ready = 1'b0;
            redirect_valid = 1'b1;
            redirect_pc = tbl[k].rpc;
            step();
            redirect_valid = 1'b0;
            load_exp(tbl[k].a0, 16);
            @(negedge clk);
            check("t5_addr0_valid", 32'(imem_req_valid), 32'd1);
            check("t5_addr0", imem_req_addr, tbl[k].a0);
            step();
            imem_req_ready = 1'b1;
            @(negedge clk);
            check("t5_addr0_hold", imem_req_addr, tbl[k].a0);
            step();
            @(negedge clk);
            check("t5_addr1", imem_req_addr, tbl[k].a1);
            step(6);
        end

        // 6: reset asserted during FLUSH while a redirect is pending
        rst_n = 1'b0;
        lat = 3;
        step(2);
        load_exp(32'h0, 64);
        rst_n = 1'b1;
        step(2);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0100;
        step();
        redirect_pc = 32'h0000_0200;
        @(negedge clk);
        check("t6_in_flush", 32'(dbg_flush), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_if_valid", 32'(if_valid), 32'd0);
        check("t6_rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("t6_rst_flush", 32'(dbg_flush), 32'd0);
        check("t6_rst_req_addr", imem_req_addr, 32'd0);
        step(2);
        redirect_valid = 1'b0;
        load_exp(32'h0, 64);
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_resume_valid", 32'(imem_req_valid), 32'd1);
        check("t6_resume_addr", imem_req_addr, 32'h0);
        step();
        wait_if_valid("t6", 20);
        check("t6_first_if_pc", if_pc, 32'h0);
        step(10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
